// File: rtl/imem_loader_rv32i.sv
// Boot loader: streams a length-prefixed, XOR-checksummed image into
// instruction memory while holding the RV32I core in reset.
module imem_loader_rv32i #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  bidx;
  logic [23:0] wbuf;
  logic [7:0]  csum;
  logic        xfer;
  logic [16:0] cnt_inc;
  logic [16:0] len_new;

  // receive states only; decoded straight from the state register
  assign rx_ready = (state == S_LEN0) | (state == S_LEN1) |
                    (state == S_DATA) | (state == S_CSUM);
  assign xfer     = rx_valid & rx_ready;
  assign cnt_inc  = 17'(wr_count) + 17'd1;
  assign len_new  = {1'b0, rx_data, len_lo};

  // session FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_count   <= '0;
      len_lo     <= '0;
      len        <= '0;
      bidx       <= '0;
      wbuf       <= '0;
      csum       <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            wr_count   <= '0;
            csum       <= '0;
            core_rst_n <= 1'b0;
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len_lo <= rx_data;
            csum   <= csum ^ rx_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            len  <= len_new[15:0];
            csum <= csum ^ rx_data;
            bidx <= '0;
            if (len_new > CAP) begin
              state <= S_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else if (len_new == 17'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ rx_data;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_waddr <= wr_count[ADDR_W-1:0];
              imem_wdata <= {rx_data, wbuf};
              state      <= S_WRITE;
            end else begin
              wbuf[8*bidx +: 8] <= rx_data;
            end
          end
        end
        S_WRITE: begin
          wr_count <= cnt_inc[ADDR_W:0];
          if (cnt_inc == {1'b0, len}) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              done       <= 1'b1;
              core_rst_n <= 1'b1;
              state      <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Bench for imem_loader_rv32i: table of sessions plus hand-written
// overflow, random-handshake and mid-session reset sequences.
module tb_imem_loader_rv32i;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   wr_count;

  imem_loader_rv32i #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  typedef struct {
    int               n;
    logic [3:0][31:0] w;
    logic [7:0]       flip;
    logic             ex_done;
    logic             ex_err;
    logic             ex_crn;
    logic [AW:0]      ex_cnt;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] img[256];
  logic [31:0] dut_mem[256];
  vec_t        vecs[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // scoreboard: every write must match the next expected one
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      chk("we_rx_ready", 64'(rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_write: got addr=%0h want none", imem_waddr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_waddr), 64'(e.a));
        chk("wr_data", 64'(imem_wdata), 64'(e.d));
      end
      dut_mem[imem_waddr] = imem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL rx_wait: got no rx_ready want accept");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input int n, input logic [7:0] flip,
                             input bit gaps, input bit mid_start);
    logic [15:0] len;
    logic [7:0]  x;
    logic [7:0]  d;
    len = 16'(n);
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_crn", 64'(core_rst_n), 64'd0);
    chk("start_rdy", 64'(rx_ready), 64'd1);
    x = len[7:0] ^ len[15:8];
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        d = img[i][8*b +: 8];
        x = x ^ d;
        if (mid_start && i == 1 && b == 2) pulse_start();
        if (b == 3) exp_q.push_back('{a: AW'(i), d: img[i]});
        send_byte(d, gaps);
      end
    end
    send_byte(x ^ flip, gaps);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, {32'h0, 32'h0, 32'h00100113, 32'h00500093},
                8'h00, 1, 0, 1, 9'd2};
    vecs[1] = '{2, {32'h0, 32'h0, 32'h00100113, 32'h00500093},
                8'h01, 0, 1, 0, 9'd2};
    vecs[2] = '{0, {32'h0, 32'h0, 32'h0, 32'h0},
                8'h00, 1, 0, 1, 9'd0};
    vecs[3] = '{3, {32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF},
                8'h80, 0, 1, 0, 9'd3};
    vecs[4] = '{4, {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678},
                8'h00, 1, 0, 1, 9'd4};
    for (int i = 0; i < 256; i++) dut_mem[i] = '0;

    rst = 1'b1;
    start = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(rx_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_crn", 64'(core_rst_n), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cnt", 64'(wr_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) img[i] = vecs[v].w[i];
      run_session(vecs[v].n, vecs[v].flip, 0, 0);
      chk($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].ex_done));
      chk($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].ex_err));
      chk($sformatf("v%0d_crn", v), 64'(core_rst_n), 64'(vecs[v].ex_crn));
      chk($sformatf("v%0d_cnt", v), 64'(wr_count), 64'(vecs[v].ex_cnt));
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
      chk($sformatf("v%0d_rdy", v), 64'(rx_ready), 64'd0);
      chk($sformatf("v%0d_q", v), 64'(exp_q.size()), 64'd0);
    end

    // length overflow: 0x0101 > 256 words
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_rdy", 64'(rx_ready), 64'd0);
    chk("ovf_busy", 64'(busy), 64'd0);
    chk("ovf_crn", 64'(core_rst_n), 64'd0);
    chk("ovf_cnt", 64'(wr_count), 64'd0);
    repeat (3) @(negedge clk);
    chk("ovf_rdy2", 64'(rx_ready), 64'd0);

    // exact fill: N = 256
    for (int i = 0; i < 256; i++) img[i] = {8'(i), 8'(255 - i), 8'(i * 3), 8'hA5};
    run_session(256, 8'h00, 0, 0);
    chk("fill_done", 64'(done), 64'd1);
    chk("fill_cnt", 64'(wr_count), 64'd256);
    chk("fill_q", 64'(exp_q.size()), 64'd0);
    chk("fill_last", 64'(dut_mem[255]), 64'(img[255]));

    // random handshake with an ignored start pulse mid-session
    for (int i = 0; i < 6; i++) img[i] = $urandom;
    run_session(6, 8'h00, 1, 1);
    chk("rnd_done", 64'(done), 64'd1);
    chk("rnd_cnt", 64'(wr_count), 64'd6);
    chk("rnd_q", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rnd_img%0d", i), 64'(dut_mem[i]), 64'(img[i]));

    // async reset during byte 2 of word 1
    img[0] = 32'h00500093;
    img[1] = 32'h00100113;
    dut_mem[0] = '0;
    dut_mem[1] = '0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) exp_q.push_back('{a: AW'(0), d: img[0]});
      send_byte(img[0][8*b +: 8], 0);
    end
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    rx_data = img[1][23:16];
    rx_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", 64'(rx_ready), 64'd0);
    chk("arst_we", 64'(imem_we), 64'd0);
    chk("arst_addr", 64'(imem_waddr), 64'd0);
    chk("arst_data", 64'(imem_wdata), 64'd0);
    chk("arst_crn", 64'(core_rst_n), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_cnt", 64'(wr_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("arst_part", 64'(dut_mem[0]), 64'(img[0]));
    chk("arst_part1", 64'(dut_mem[1]), 64'd0);
    run_session(2, 8'h00, 0, 0);
    chk("rel_done", 64'(done), 64'd1);
    chk("rel_cnt", 64'(wr_count), 64'd2);
    chk("rel_img1", 64'(dut_mem[1]), 64'(img[1]));
    chk("rel_q", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
